// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the FFT scheduler and butterfly datapath.
package fft_pkg;

    localparam int LOG2N_DEFAULT = 4;

    typedef logic [LOG2N_DEFAULT-1:0] addr_t;
    typedef logic [LOG2N_DEFAULT-2:0] tw_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
    } complex_t;

endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: maps (stage, butterfly index) to the two leg addresses and the twiddle index.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEFAULT,
    localparam int SW = $clog2(LOG2N) + 1
) (
    input  logic [SW-1:0]    stage,
    input  logic [LOG2N-2:0] k,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw
);

    logic [LOG2N-1:0] kx, span, pos;

    // Insert a zero bit at position `stage` of k to get the upper leg; lower leg sits span above.
    always_comb begin
        kx     = {1'b0, k};
        span   = LOG2N'(1) << stage;
        pos    = kx & (span - LOG2N'(1));
        addr_a = (((kx >> stage) << 1) << stage) | pos;
        addr_b = addr_a + span;
        tw     = (LOG2N-1)'(pos << (SW'(LOG2N - 1) - stage));
    end

endmodule

// File: rtl/fft_ctrl.sv
// fft_ctrl: in-place radix-2 DIT FFT scheduler issuing butterfly reads and delayed write-backs.
// Define FFT_CTRL_STALL_EN to add i_stall, which pauses butterfly issue while in RUN.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N      = LOG2N_DEFAULT,
    parameter int BF_LATENCY = 2,
    parameter int RD_LATENCY = 1,
    localparam int SW   = $clog2(LOG2N) + 1,
    localparam int PIPE = RD_LATENCY + BF_LATENCY
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
`ifdef FFT_CTRL_STALL_EN
    input  logic             i_stall,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic [SW-1:0]    o_stage,
    output logic             o_rd_en,
    output logic [LOG2N-1:0] o_rd_addr_a,
    output logic [LOG2N-1:0] o_rd_addr_b,
    output logic [LOG2N-2:0] o_tw_addr,
    output logic             o_wr_en,
    output logic [LOG2N-1:0] o_wr_addr_a,
    output logic [LOG2N-1:0] o_wr_addr_b
);

    localparam int KW = LOG2N - 1;
    localparam int CW = $clog2(PIPE + 1);
    localparam int DW = 2 * LOG2N + 1;

    state_t           state, ns;
    logic [SW-1:0]    stage, nstage;
    logic [KW-1:0]    k, nk;
    logic [CW-1:0]    cnt, ncnt;
    logic             stall, rd_en_n, busy_n, done_n;
    logic [LOG2N-1:0] ga, gb;
    logic [KW-1:0]    gt;
    logic [DW-1:0]    dl [PIPE];

`ifdef FFT_CTRL_STALL_EN
    assign stall = i_stall;
`else
    assign stall = 1'b0;
`endif

    fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
        .stage  (nstage),
        .k      (nk),
        .addr_a (ga),
        .addr_b (gb),
        .tw     (gt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            stage       <= '0;
            k           <= '0;
            cnt         <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_rd_en     <= 1'b0;
            o_rd_addr_a <= '0;
            o_rd_addr_b <= '0;
            o_tw_addr   <= '0;
            for (int i = 0; i < PIPE; i++) dl[i] <= '0;
        end else begin
            state       <= ns;
            stage       <= nstage;
            k           <= nk;
            cnt         <= ncnt;
            o_busy      <= busy_n;
            o_done      <= done_n;
            o_rd_en     <= rd_en_n;
            o_rd_addr_a <= rd_en_n ? ga : '0;
            o_rd_addr_b <= rd_en_n ? gb : '0;
            o_tw_addr   <= rd_en_n ? gt : '0;
            dl[0]       <= {o_rd_en, o_rd_addr_a, o_rd_addr_b};
            for (int i = 1; i < PIPE; i++) dl[i] <= dl[i-1];
        end
    end

    // k is the butterfly shown on the read port; it only advances once that read has actually issued.
    always_comb begin
        ns     = state;
        nstage = stage;
        nk     = k;
        ncnt   = cnt;
        case (state)
            IDLE: begin
                if (i_start) begin
                    ns     = RUN;
                    nstage = '0;
                    nk     = '0;
                end
            end
            RUN: begin
                if (o_rd_en && k == '1) begin
                    ns   = DRAIN;
                    ncnt = '0;
                end else begin
                    nk = o_rd_en ? k + KW'(1) : k;
                end
            end
            DRAIN: begin
                if (cnt == CW'(PIPE - 1)) begin
                    if (stage == SW'(LOG2N - 1)) begin
                        ns = DONE;
                    end else begin
                        ns     = RUN;
                        nstage = stage + SW'(1);
                        nk     = '0;
                    end
                end else begin
                    ncnt = cnt + CW'(1);
                end
            end
            default: ns = IDLE;
        endcase
    end

    always_comb begin
        rd_en_n = ns == RUN && !(state == RUN && stall);
        busy_n  = ns != IDLE;
        done_n  = ns == DONE;
    end

    assign o_stage = stage;
    assign {o_wr_en, o_wr_addr_a, o_wr_addr_b} = dl[PIPE-1];

endmodule
